vga_line_scheduler: RTL and testbench

- Sequences the PPU-to-VGA scanout path through an external 2-bank × 256-entry × 2-bit ping-pong line buffer.
- Requests NES lines from the PPU pixel stream and writes each one into the fill bank.
- Hands completed banks to the VGA reader, which shows each NES line on SCALE consecutive VGA lines (2× vertical).
- Detects and counts reader underruns.

---
 rtl/vga_pkg.sv | 19 +
 rtl/line_fill_ctr.sv | 46 ++++
 rtl/vga_line_scheduler.sv | 148 ++++++++++++++
 tb/tb_vga_line_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the PPU-to-VGA line scheduler.
package vga_pkg;

    localparam int LINE_PIXELS    = 256;
    localparam int SCALE          = 2;
    localparam int H_VISIBLE_AREA = 640;
    localparam int V_VISIBLE_AREA = 480;

    localparam logic [7:0] NES_LINES = 8'd240;
    localparam logic [7:0] LAST_PIX  = 8'(LINE_PIXELS - 1);

    localparam int REP_W = $clog2(SCALE + 1);
    localparam logic [REP_W-1:0] SCALE_R = REP_W'(SCALE);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} sched_state_t;

    typedef logic [1:0] nes_pix_t;

endpackage

// File: rtl/line_fill_ctr.sv
// Pixel counter for the fill bank: terminal-count flag plus registered
// line-buffer write port (one cycle behind the accepted transfer).
module line_fill_ctr
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       xfer,
    input  logic       bank,
    input  nes_pix_t   pix,
    output logic       tc,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [7:0] wr_addr,
    output nes_pix_t   wr_data
);

    logic [7:0] cnt;

    assign tc = (cnt == LAST_PIX);

    // The counter wraps naturally after the last pixel, so a finished line
    // leaves it at zero for the next request; clear only matters on resync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_bank <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (clear) begin
            cnt   <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                wr_bank <= bank;
                wr_addr <= cnt;
                wr_data <= pix;
                cnt     <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vga_line_scheduler.sv
// Ping-pong line-buffer scheduler between the PPU pixel stream and the VGA reader.
// Build option VGA_UNDERRUN_BLANK_EN: blank the VGA line on an underrun instead of repeating.
module vga_line_scheduler
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vga_prefetch,
    input  logic       vga_line_start,
    input  logic       pix_valid,
    input  nes_pix_t   pix_data,
    output logic       pix_ready,
    output logic       line_req,
    output logic [7:0] line_req_num,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [7:0] wr_addr,
    output nes_pix_t   wr_data,
    output logic       rd_bank,
    output logic       line_ready,
    output logic [7:0] underrun_cnt
);

    sched_state_t     state, state_next;
    logic [7:0]       fill_line, fill_line_inc;
    logic             fill_bank;
    logic             have_line;
    logic [REP_W-1:0] rep_cnt;
    logic             xfer, tc;
    logic             do_init_swap, do_swap, do_exhaust, do_underrun, do_rep_inc;

    assign xfer          = pix_valid && pix_ready;
    assign fill_line_inc = fill_line + 8'd1;
    assign line_req_num  = fill_line;

    line_fill_ctr u_fill_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (vga_prefetch),
        .xfer    (xfer),
        .bank    (fill_bank),
        .pix     (pix_data),
        .tc      (tc),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        pix_ready    = 1'b0;
        line_req     = 1'b0;
        do_init_swap = 1'b0;
        do_swap      = 1'b0;
        do_exhaust   = 1'b0;
        do_underrun  = 1'b0;
        do_rep_inc   = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            REQ: begin
                line_req   = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                pix_ready = 1'b1;
                if (xfer && tc) state_next = DONE;
            end
            DONE: begin
                if (!have_line) begin
                    do_init_swap = 1'b1;
                    state_next   = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        // A line_start that finds the fill still running is an underrun even
        // if the last pixel lands in the same cycle; the swap waits a line.
        if (vga_line_start && have_line) begin
            if (rep_cnt < SCALE_R) begin
                do_rep_inc = 1'b1;
            end else if (state == DONE) begin
                do_swap    = 1'b1;
                state_next = (fill_line_inc < NES_LINES) ? REQ : IDLE;
            end else if (state == IDLE && fill_line == NES_LINES) begin
                do_exhaust = 1'b1;
            end else begin
                do_underrun = 1'b1;
            end
        end
        if (vga_prefetch) state_next = REQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line    <= '0;
            fill_bank    <= 1'b0;
            rd_bank      <= 1'b0;
            have_line    <= 1'b0;
            rep_cnt      <= '0;
            underrun_cnt <= '0;
        end else if (vga_prefetch) begin
            fill_line    <= '0;
            fill_bank    <= 1'b0;
            have_line    <= 1'b0;
            rep_cnt      <= '0;
            underrun_cnt <= '0;
        end else begin
            if (do_init_swap) begin
                rd_bank   <= fill_bank;
                have_line <= 1'b1;
                rep_cnt   <= '0;
                fill_bank <= ~fill_bank;
                fill_line <= fill_line_inc;
            end
            if (do_rep_inc) rep_cnt <= rep_cnt + REP_W'(1);
            if (do_swap) begin
                rd_bank   <= ~rd_bank;
                rep_cnt   <= REP_W'(1);
                fill_bank <= ~fill_bank;
                fill_line <= fill_line_inc;
            end
            if (do_exhaust) have_line <= 1'b0;
            if (do_underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

`ifdef VGA_UNDERRUN_BLANK_EN
    logic blank;

    // Blank holds until the reader gets a fresh line or the frame restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 blank <= 1'b0;
        else if (vga_prefetch || do_swap || do_exhaust) blank <= 1'b0;
        else if (do_underrun)                       blank <= 1'b1;
    end

    assign line_ready = have_line && !blank;
`else
    assign line_ready = have_line;
`endif

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Scoreboard bench for vga_line_scheduler: a PPU model streams requested lines
// and every write and line request is checked against queued expectations.
module tb_vga_line_scheduler;

    logic       clk;
    logic       rst_n;
    logic       vga_prefetch;
    logic       vga_line_start;
    logic       pix_valid;
    logic [1:0] pix_data;
    logic       pix_ready;
    logic       line_req;
    logic [7:0] line_req_num;
    logic       wr_en;
    logic       wr_bank;
    logic [7:0] wr_addr;
    logic [1:0] wr_data;
    logic       rd_bank;
    logic       line_ready;
    logic [7:0] underrun_cnt;

`ifdef VGA_UNDERRUN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    int          compared = 0;
    int          mismatched = 0;
    logic [10:0] exp_wr[$];
    int          exp_req[$];
    int          wr_popped = 0;
    int          ppu_line = 0;
    int          ppu_idx = 0;
    bit          ppu_active = 1'b0;
    bit          ppu_pause = 1'b0;
    int          hold_line = -1;

    vga_line_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vga_prefetch   (vga_prefetch),
        .vga_line_start (vga_line_start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .line_req       (line_req),
        .line_req_num   (line_req_num),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_bank        (rd_bank),
        .line_ready     (line_ready),
        .underrun_cnt   (underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PPU model and write scoreboard, both working on the falling edge.
    initial begin
        logic [10:0] exp;
        pix_valid = 1'b0;
        pix_data  = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
                compared++;
                wr_popped++;
                if (exp_wr.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL wr_unexpected: got bank %0d addr %0d data %0d, required no write", wr_bank, wr_addr, wr_data);
                end else begin
                    exp = exp_wr.pop_front();
                    if ({wr_bank, wr_addr, wr_data} !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL wr_port: got bank %0d addr %0d data %0d, required bank %0d addr %0d data %0d",
                                 wr_bank, wr_addr, wr_data, exp[10], exp[9:2], exp[1:0]);
                    end
                end
            end
            if (rst_n && line_req) begin
                compared++;
                if (exp_req.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL line_req_unexpected: got num %0d, required no request", line_req_num);
                    ppu_line = int'(line_req_num);
                end else begin
                    ppu_line = exp_req.pop_front();
                    if (line_req_num !== 8'(ppu_line)) begin
                        mismatched++;
                        $display("[TB] FAIL line_req_num: got %0d, required %0d", line_req_num, ppu_line);
                    end
                end
                ppu_idx    = 0;
                ppu_active = 1'b1;
            end
            pix_valid = ppu_active && !ppu_pause && (ppu_line != hold_line);
            pix_data  = 2'((ppu_line * 3 + ppu_idx) ^ (ppu_idx >> 2));
            if (pix_valid && pix_ready) begin
                exp_wr.push_back({ppu_line[0], 8'(ppu_idx), pix_data});
                ppu_idx++;
                if (ppu_idx == 256) ppu_active = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line_start;
        vga_line_start = 1'b1;
        tick;
        vga_line_start = 1'b0;
    endtask

    task automatic pulse_prefetch;
        vga_prefetch = 1'b1;
        tick;
        vga_prefetch = 1'b0;
    endtask

    task automatic test_reset;
        int seen;
        rst_n          = 1'b0;
        vga_prefetch   = 1'b0;
        vga_line_start = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        compared++;
        if ({pix_ready, line_req, line_req_num} !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got ready %0d req %0d num %0d, required all 0", pix_ready, line_req, line_req_num);
        end
        compared++;
        if ({wr_en, wr_bank, wr_addr, wr_data} !== 12'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_wr: got en %0d bank %0d addr %0d data %0d, required all 0", wr_en, wr_bank, wr_addr, wr_data);
        end
        compared++;
        if ({rd_bank, line_ready, underrun_cnt} !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got rd_bank %0d ready %0d underrun %0d, required all 0", rd_bank, line_ready, underrun_cnt);
        end
        seen = 0;
        pulse_line_start;
        for (int i = 0; i < 1000; i++) begin
            if (pix_ready || line_req || line_ready || wr_en) seen++;
            tick;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_quiet: got %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_first_line;
        int budget;
        exp_req.push_back(0);
        exp_req.push_back(1);
        wr_popped = 0;
        pulse_prefetch;
        budget = 400;
        while (line_ready !== 1'b1 && budget > 0) begin
            tick;
            budget--;
        end
        compared++;
        if (budget == 0) begin
            mismatched++;
            $display("[TB] FAIL first_line_timeout: got line_ready %0d, required 1 within 400 cycles", line_ready);
        end else begin
            compared++;
            if (rd_bank !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL first_rd_bank: got %0d, required 0", rd_bank);
            end
            compared++;
            if (wr_popped !== 256 || pix_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL first_fill_end: got writes %0d pix_ready %0d, required 256 and 0", wr_popped, pix_ready);
            end
            compared++;
            if (line_req !== 1'b1 || line_req_num !== 8'd1) begin
                mismatched++;
                $display("[TB] FAIL second_req: got req %0d num %0d, required 1 and 1", line_req, line_req_num);
            end
        end
        repeat (300) tick;
        compared++;
        if (wr_popped !== 512 || pix_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL second_fill: got writes %0d pix_ready %0d, required 512 and 0", wr_popped, pix_ready);
        end
    endtask

    task automatic test_full_frame;
        logic exp_bank;
        for (int l = 0; l < 240; l++) exp_req.push_back(l);
        pulse_prefetch;
        repeat (600) tick;
        for (int i = 1; i <= 480; i++) begin
            pulse_line_start;
            exp_bank = 1'(((i - 1) / 2) % 2);
            compared++;
            if (rd_bank !== exp_bank) begin
                mismatched++;
                $display("[TB] FAIL frame_rd_bank: line_start %0d got %0d, required %0d", i, rd_bank, exp_bank);
            end
            repeat (134) tick;
        end
        compared++;
        if (underrun_cnt !== 8'd0 || line_ready !== 1'b1 || exp_req.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL frame_end: got underrun %0d ready %0d pending_req %0d, required 0 1 0",
                     underrun_cnt, line_ready, exp_req.size());
        end
        pulse_line_start;
        compared++;
        if (line_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL frame_exhausted: got line_ready %0d, required 0", line_ready);
        end
    endtask

    task automatic test_underrun_stall;
        int budget;
        logic exp_lr;
        exp_lr = BLANK ? 1'b0 : 1'b1;
        for (int l = 0; l <= 6; l++) exp_req.push_back(l);
        hold_line = 5;
        pulse_prefetch;
        repeat (600) tick;
        for (int i = 1; i <= 10; i++) begin
            pulse_line_start;
            repeat (134) tick;
        end
        for (int k = 1; k <= 3; k++) begin
            pulse_line_start;
            compared++;
            if (underrun_cnt !== 8'(k) || rd_bank !== 1'b0 || line_ready !== exp_lr) begin
                mismatched++;
                $display("[TB] FAIL stall_underrun: got cnt %0d rd_bank %0d ready %0d, required %0d 0 %0d",
                         underrun_cnt, rd_bank, line_ready, k, exp_lr);
            end
            repeat (134) tick;
        end
        hold_line = -1;
        budget = 400;
        while (pix_ready !== 1'b0 && budget > 0) begin
            tick;
            budget--;
        end
        compared++;
        if (budget == 0) begin
            mismatched++;
            $display("[TB] FAIL stall_fill_timeout: got pix_ready %0d, required 0 within 400 cycles", pix_ready);
        end
        tick;
        pulse_line_start;
        compared++;
        if (rd_bank !== 1'b1 || line_ready !== 1'b1 || underrun_cnt !== 8'd3) begin
            mismatched++;
            $display("[TB] FAIL stall_swap: got rd_bank %0d ready %0d cnt %0d, required 1 1 3", rd_bank, line_ready, underrun_cnt);
        end
    endtask

    task automatic test_prefetch_abort;
        int budget;
        budget = 600;
        while (!(wr_en === 1'b1 && wr_addr === 8'd100) && budget > 0) begin
            tick;
            budget--;
        end
        compared++;
        if (budget == 0) begin
            mismatched++;
            $display("[TB] FAIL abort_wait: got wr_addr %0d, required 100 within 600 cycles", wr_addr);
        end
        ppu_pause = 1'b1;
        exp_req.push_back(0);
        exp_req.push_back(1);
        pulse_prefetch;
        compared++;
        if (line_ready !== 1'b0 || underrun_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL abort_status: got ready %0d cnt %0d, required 0 0", line_ready, underrun_cnt);
        end
        ppu_pause = 1'b0;
        budget = 400;
        while (line_ready !== 1'b1 && budget > 0) begin
            tick;
            budget--;
        end
        compared++;
        if (budget == 0 || rd_bank !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_refill: got ready %0d rd_bank %0d, required 1 0", line_ready, rd_bank);
        end
        repeat (300) tick;
    endtask

    task automatic test_saturation;
        logic exp_lr;
        exp_lr = BLANK ? 1'b0 : 1'b1;
        exp_req.push_back(2);
        ppu_pause = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pulse_line_start;
            if (i == 3) begin
                compared++;
                if (rd_bank !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL sat_swap: got rd_bank %0d, required 1", rd_bank);
                end
            end
            repeat (2) tick;
        end
        for (int k = 1; k <= 300; k++) begin
            pulse_line_start;
            compared++;
            if (line_ready !== exp_lr) begin
                mismatched++;
                $display("[TB] FAIL sat_line_ready: underrun %0d got %0d, required %0d", k, line_ready, exp_lr);
            end
            tick;
        end
        compared++;
        if (underrun_cnt !== 8'd255) begin
            mismatched++;
            $display("[TB] FAIL sat_count: got %0d, required 255", underrun_cnt);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        vga_prefetch   = 1'b0;
        vga_line_start = 1'b0;
        test_reset;
        test_first_line;
        test_full_frame;
        test_underrun_stall;
        test_prefetch_abort;
        test_saturation;
        compared++;
        if (exp_wr.size() !== 0 || exp_req.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got pending writes %0d requests %0d, required 0 0", exp_wr.size(), exp_req.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
